// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mem_arb_pkg                                                            |
// | Shared defaults and FSM state encoding for the two-port memory         |
// | arbiter.                                                               |
// | Contents: ADDR_W_DEF, DATA_W_DEF, NUM_REQ, state_e                     |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;
  localparam int NUM_REQ    = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mem_arbiter_if                                                         |
// | Bundle of both requester ports and the synchronous memory port.        |
// | Requesters : req0/1, we0/1, addr0/1, wdata0/1 -> gnt0/1, ack0/1,       |
// |              rdata0/1                                                  |
// | Memory     : cs, we, address, data_out -> data_in                      |
// | Modports   : slave (arbiter view), master (environment view)           |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              cs;
  logic              we;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] data_in;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, data_in,
    output gnt0, gnt1, ack0, ack1, rdata0, rdata1, cs, we, address, data_out
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, data_in,
    input  gnt0, gnt1, ack0, ack1, rdata0, rdata1, cs, we, address, data_out
  );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_arbiter2.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | rr_arbiter2                                                            |
// | Two-way round-robin pick with a 1-bit last-grant pointer.              |
// | req_i  : request vector                                                |
// | last_i : port granted most recently                                    |
// | pick_o : one-hot winner (all zero when nobody requests)                |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               last_i,
  output logic [NUM_REQ-1:0] pick_o
);

  always_comb begin
    pick_o = req_i;
    // On a tie the port that was not granted last time wins.
    if (req_i == 2'b11) begin
      pick_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mem_arbiter                                                            |
// | Shares one synchronous single-port memory between two requesters.      |
// | One access takes IDLE -> ACCESS -> CAPTURE; every output registered.   |
// | clk, rst_n : clock, asynchronous active-low reset                      |
// | bus        : mem_arbiter_if.slave (requester and memory signals)       |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
)(
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  state_e              state_q, state_d;
  logic                last_q, last_d;   // port granted most recently
  logic                win_q, win_d;     // port owning the current access
  logic                rd_q, rd_d;       // current access is a read
  logic                cs_q, cs_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic [NUM_REQ-1:0]  pick;

  rr_arbiter2 u_rr (
    .req_i  ({bus.req1, bus.req0}),
    .last_i (last_q),
    .pick_o (pick)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    win_d    = win_q;
    rd_d     = rd_q;
    cs_d     = cs_q;
    we_d     = we_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    gnt_d    = '0;
    ack_d    = '0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      ST_IDLE: begin
        cs_d = 1'b0;
        we_d = 1'b0;
        if (|pick) begin
          win_d   = pick[1];
          last_d  = pick[1];
          rd_d    = pick[1] ? ~bus.we1 : ~bus.we0;
          cs_d    = 1'b1;
          we_d    = pick[1] ? bus.we1 : bus.we0;
          addr_d  = pick[1] ? bus.addr1 : bus.addr0;
          dout_d  = pick[1] ? bus.wdata1 : bus.wdata0;
          gnt_d   = pick;
          state_d = ST_ACCESS;
        end
      end
      // The memory samples at the edge closing ACCESS, so cs/we are
      // released on that same edge and read 0 throughout CAPTURE.
      ST_ACCESS: begin
        cs_d    = 1'b0;
        we_d    = 1'b0;
        state_d = ST_CAPTURE;
      end
      // data_in now holds the word addressed during ACCESS.
      ST_CAPTURE: begin
        if (rd_q) begin
          if (win_q) rdata1_d = bus.data_in;
          else       rdata0_d = bus.data_in;
        end
        ack_d[win_q] = 1'b1;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;          // port 0 wins the first tie
      win_q    <= 1'b0;
      rd_q     <= 1'b0;
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      win_q    <= win_d;
      rd_q     <= rd_d;
      cs_q     <= cs_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign bus.gnt0     = gnt_q[0];
  assign bus.gnt1     = gnt_q[1];
  assign bus.ack0     = ack_q[0];
  assign bus.ack1     = ack_q[1];
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;
  assign bus.cs       = cs_q;
  assign bus.we       = we_q;
  assign bus.address  = addr_q;
  assign bus.data_out = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mem_arbiter                                                         |
// | Self-checking bench: a transaction-schedule model predicts every       |
// | output each cycle; directed sequences add literal expectations.        |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 7;
  localparam int DW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- synchronous memory (environment) ----------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) mem[i] <= DW'(i * 3 + 1);

  always @(posedge clk) begin
    if (bus.cs) begin
      if (bus.we) mem[bus.address] <= bus.data_out;
      bus.data_in <= mem[bus.address];
    end
  end

  // ---------------- reference model ----------------
  // Each accepted request becomes a scheduled transaction: outputs for the
  // grant cycle, memory commit one edge later, ack two edges later and the
  // next arbitration three edges later.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) ref_mem[i] = DW'(i * 3 + 1);

  int ecnt = 0, free_e = 0, ack_e = -1, commit_e = -1;
  bit last_port = 1'b1;
  bit m_port = 1'b0, m_rd = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;

  logic e_gnt0 = 0, e_gnt1 = 0, e_ack0 = 0, e_ack1 = 0, e_cs = 0, e_we = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_dout = '0, e_rd0 = '0, e_rd1 = '0;

  task automatic model_reset();
    e_gnt0 = 0; e_gnt1 = 0; e_ack0 = 0; e_ack1 = 0; e_cs = 0; e_we = 0;
    e_addr = '0; e_dout = '0; e_rd0 = '0; e_rd1 = '0;
    last_port = 1'b1;
    free_e = 0; ack_e = -1; commit_e = -1;
  endtask

  task automatic model_edge();
    ecnt++;
    e_gnt0 = 0; e_gnt1 = 0; e_ack0 = 0; e_ack1 = 0; e_cs = 0; e_we = 0;
    if (ecnt == commit_e && !m_rd) ref_mem[m_addr] = m_wdata;
    if (ecnt == ack_e) begin
      if (m_port) begin
        e_ack1 = 1;
        if (m_rd) e_rd1 = ref_mem[m_addr];
      end else begin
        e_ack0 = 1;
        if (m_rd) e_rd0 = ref_mem[m_addr];
      end
    end
    if (ecnt >= free_e && (bus.req0 || bus.req1)) begin
      m_port    = (bus.req0 && bus.req1) ? !last_port : bus.req1;
      last_port = m_port;
      m_rd      = m_port ? !bus.we1 : !bus.we0;
      m_addr    = m_port ? bus.addr1 : bus.addr0;
      m_wdata   = m_port ? bus.wdata1 : bus.wdata0;
      if (m_port) e_gnt1 = 1; else e_gnt0 = 1;
      e_cs = 1; e_we = !m_rd; e_addr = m_addr; e_dout = m_wdata;
      commit_e = ecnt + 1; ack_e = ecnt + 2; free_e = ecnt + 3;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else        model_edge();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    chk("gnt0", bus.gnt0, e_gnt0);
    chk("gnt1", bus.gnt1, e_gnt1);
    chk("ack0", bus.ack0, e_ack0);
    chk("ack1", bus.ack1, e_ack1);
    chk("cs", bus.cs, e_cs);
    chk("we", bus.we, e_we);
    chk("address", bus.address, e_addr);
    chk("data_out", bus.data_out, e_dout);
    chk("rdata0", bus.rdata0, e_rd0);
    chk("rdata1", bus.rdata1, e_rd1);
    chk("gnt_excl", bus.gnt0 & bus.gnt1, 0);
    chk("ack_excl", bus.ack0 & bus.ack1, 0);
  end

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int gp[$];
    int gc[$];
    bit seen;
    int wait_n;

    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;

    repeat (2) @(negedge clk);
    chk("rst_cs", bus.cs, 0);
    chk("rst_rdata0", bus.rdata0, 0);
    #1 rst_n = 1'b1;

    // Single write to the top address.
    @(negedge clk);
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 7'h7F; bus.wdata0 = 8'h5A;
    @(negedge clk);
    chk("w_gnt0", bus.gnt0, 1);
    chk("w_cs", bus.cs, 1);
    chk("w_we", bus.we, 1);
    chk("w_address", bus.address, 7'h7F);
    chk("w_data_out", bus.data_out, 8'h5A);
    bus.req0 = 0;
    @(negedge clk);
    chk("w_ack0_early", bus.ack0, 0);
    @(negedge clk);
    chk("w_ack0", bus.ack0, 1);

    // Read-back on port 1.
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 7'h7F;
    @(negedge clk);
    chk("r_gnt1", bus.gnt1, 1);
    bus.req1 = 0;
    repeat (2) @(negedge clk);
    chk("r_ack1", bus.ack1, 1);
    chk("r_rdata1", bus.rdata1, 8'h5A);
    chk("r_rdata0_kept", bus.rdata0, 0);

    // Withdrawn request: never seen by an edge.
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 7'h55; bus.wdata0 = 8'hEE;
    #2 bus.req0 = 0;
    @(negedge clk);
    chk("wd_cs", bus.cs, 0);
    chk("wd_gnt0", bus.gnt0, 0);
    // Pointer still names port 1, so a tie goes to port 0.
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 7'h7F;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 7'h10;
    @(negedge clk);
    chk("tie_gnt0", bus.gnt0, 1);
    bus.req0 = 0;
    seen = 0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk);
      if (bus.gnt1) seen = 1;
    end
    chk("tie_gnt1_seen", seen, 1);
    bus.req1 = 0;
    repeat (3) @(negedge clk);

    // Late request: port 1 rises during port 0's ACCESS.
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 7'h10; bus.wdata0 = 8'h33;
    @(negedge clk);
    chk("late_gnt0", bus.gnt0, 1);
    bus.req0 = 0;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 7'h10;
    wait_n = 0; seen = 0;
    for (int k = 1; k <= 6 && !seen; k++) begin
      @(negedge clk);
      if (bus.gnt1) begin seen = 1; wait_n = k; end
    end
    chk("late_gnt1_delay", wait_n, 3);
    bus.req1 = 0;
    repeat (2) @(negedge clk);
    chk("late_ack1", bus.ack1, 1);
    chk("late_rdata1", bus.rdata1, 8'h33);
    @(negedge clk);

    // Reset during ACCESS, then continuous contention.
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 7'h20; bus.wdata0 = 8'h77;
    @(negedge clk);
    chk("ra_gnt0", bus.gnt0, 1);
    bus.we0 = 0; bus.addr0 = 7'h21;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 7'h22;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("ra_cs", bus.cs, 0);
    chk("ra_ack0", bus.ack0, 0);
    chk("ra_address", bus.address, 0);
    chk("ra_rdata1", bus.rdata1, 0);
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (bus.gnt0) begin gp.push_back(0); gc.push_back(k); end
      if (bus.gnt1) begin gp.push_back(1); gc.push_back(k); end
    end
    chk("cont_count", gp.size(), 5);
    if (gp.size() > 0) chk("cont_first_cycle", gc[0], 1);
    for (int i = 0; i < 4; i++) begin
      if (i < gp.size()) chk("cont_port", gp[i], i % 2);
      if (i + 1 < gp.size()) chk("cont_spacing", gc[i+1] - gc[i], 3);
    end
    bus.req0 = 0; bus.req1 = 0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
